// File: rtl/matrix_result_slave.sv
// Result buffer for the matrix master's four-word burst; host reads words/status and clears.
// Optional MATRIX_SLAVE_SEQ_CHECK_EN enforces in-order fill and reports out-of-order writes as err.
module matrix_result_slave #(
  parameter logic [7:0] BASE_ADDR = 8'h60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_req,
  input  logic        M_wr,
  input  logic [7:0]  M_address,
  input  logic [31:0] M_din,
  output logic        M_ack,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [3:0]  S_address,
  input  logic [31:0] S_din,
  output logic [31:0] S_dout,
  output logic        s_interrupt
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FULL = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] words_q [4];
  logic [31:0] words_d [4];
  logic [3:0]  mask_q, mask_d;
  logic [2:0]  count_q, count_d;
  logic        dup_q, dup_d;
  logic        ovr_q, ovr_d;
  logic        err_q, err_d;
  logic        m_ack_q, irq_q;
  logic [31:0] s_dout_q;

  logic [7:0]  m_off;
  logic        m_hit;
  logic [1:0]  m_idx;
  logic        clr;
  logic [31:0] status;
  logic [31:0] rd_data;
  logic        unused_din;

  // Offset subtraction decodes BASE_ADDR..BASE_ADDR+3 as one 4-entry window.
  assign m_off      = M_address - BASE_ADDR;
  assign m_hit      = M_req && M_wr && (m_off < 8'd4);
  assign m_idx      = m_off[1:0];
  assign clr        = S_sel && S_wr && (S_address == 4'h5) && S_din[0];
  assign status     = {24'b0, err_q, ovr_q, dup_q, state_q == FULL, mask_q};
  assign unused_din = ^S_din[31:1];

  always_comb begin
    rd_data = '0;
    case (S_address)
      4'h0, 4'h1, 4'h2, 4'h3: rd_data = words_q[S_address[1:0]];
      4'h4:                   rd_data = status;
      default:                rd_data = '0;
    endcase
  end

  // Clear has priority over a same-cycle master write; the write is dropped but still acked.
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    mask_d  = mask_q;
    count_d = count_q;
    dup_d   = dup_q;
    ovr_d   = ovr_q;
    err_d   = err_q;
    if (clr) begin
      state_d = IDLE;
      for (int i = 0; i < 4; i++) words_d[i] = '0;
      mask_d  = '0;
      count_d = '0;
      dup_d   = 1'b0;
      ovr_d   = 1'b0;
      err_d   = 1'b0;
    end else if (m_hit) begin
      if (state_q == FULL) begin
        ovr_d = 1'b1;
`ifdef MATRIX_SLAVE_SEQ_CHECK_EN
      end else if (m_idx == count_q[1:0]) begin
        words_d[m_idx] = M_din;
        mask_d[m_idx]  = 1'b1;
        count_d        = count_q + 3'd1;
        state_d        = (count_q == 3'd3) ? FULL : FILL;
      end else begin
        err_d = 1'b1;
      end
`else
      end else if (mask_q[m_idx]) begin
        words_d[m_idx] = M_din;
        dup_d          = 1'b1;
      end else begin
        words_d[m_idx] = M_din;
        mask_d[m_idx]  = 1'b1;
        count_d        = count_q + 3'd1;
        state_d        = (mask_d == 4'hF) ? FULL : FILL;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      for (int i = 0; i < 4; i++) words_q[i] <= '0;
      mask_q   <= '0;
      count_q  <= '0;
      dup_q    <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
      m_ack_q  <= 1'b0;
      irq_q    <= 1'b0;
      s_dout_q <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      dup_q   <= dup_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
      m_ack_q <= m_hit;
      irq_q   <= (state_d == FULL);
      if (S_sel && !S_wr) s_dout_q <= rd_data;
    end
  end

  assign M_ack       = m_ack_q;
  assign s_interrupt = irq_q;
  assign S_dout      = s_dout_q;

endmodule

// File: tb/tb_matrix_result_slave.sv
// Scoreboard bench for matrix_result_slave: directed burst scenarios followed by random traffic.
module tb_matrix_result_slave;

  localparam int BASE = 'h60;

  logic        clk = 1'b0;
  logic        reset, M_req, M_wr, M_ack, S_sel, S_wr, s_interrupt;
  logic [7:0]  M_address;
  logic [31:0] M_din, S_din, S_dout;
  logic [3:0]  S_address;

  always #5 clk = ~clk;

  matrix_result_slave #(.BASE_ADDR(8'h60)) dut (
    .clk(clk), .reset(reset),
    .M_req(M_req), .M_wr(M_wr), .M_address(M_address), .M_din(M_din), .M_ack(M_ack),
    .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address), .S_din(S_din), .S_dout(S_dout),
    .s_interrupt(s_interrupt)
  );

  typedef struct {
    bit          ack;
    bit          irq;
    logic [31:0] dout;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_no = 0;

  // Reference: what has landed in the buffer, plus sticky flags.
  logic [31:0] ref_words [4];
  bit   [3:0]  ref_mask;
  int          ref_landed;
  bit          ref_dup, ref_ovr, ref_err;
  logic [31:0] ref_dout;

  function automatic void ref_clear();
    for (int i = 0; i < 4; i++) ref_words[i] = '0;
    ref_mask = '0; ref_landed = 0;
    ref_dup = 0; ref_ovr = 0; ref_err = 0;
  endfunction

  function automatic bit ref_full();
    return ref_landed == 4;
  endfunction

  function automatic logic [31:0] ref_read(input int off);
    if (off < 4) return ref_words[off];
    if (off == 4) return {24'b0, ref_err, ref_ovr, ref_dup, ref_full(), ref_mask};
    return 32'h0;
  endfunction

  function automatic void ref_master_write(input int idx, input logic [31:0] d);
    if (ref_full()) begin
      ref_ovr = 1;
    end else begin
`ifdef MATRIX_SLAVE_SEQ_CHECK_EN
      if (idx == ref_landed) begin
        ref_words[idx] = d; ref_mask[idx] = 1'b1; ref_landed++;
      end else begin
        ref_err = 1;
      end
`else
      ref_words[idx] = d;
      if (ref_mask[idx]) ref_dup = 1;
      else begin ref_mask[idx] = 1'b1; ref_landed++; end
`endif
    end
  endfunction

  task automatic cyc(input logic mreq, input logic mwr, input logic [7:0] addr,
                     input logic [31:0] din, input logic ssel, input logic swr,
                     input logic [3:0] saddr, input logic [31:0] sdin, input logic rst);
    exp_t e;
    int   a;
    bit   hit;
    reset = rst; M_req = mreq; M_wr = mwr; M_address = addr; M_din = din;
    S_sel = ssel; S_wr = swr; S_address = saddr; S_din = sdin;
    @(posedge clk);
    cycle_no++;
    a   = int'(addr);
    hit = mreq && mwr && (a >= BASE) && (a <= BASE + 3);
    if (rst) begin
      ref_clear();
      ref_dout = '0;
      e.ack = 0;
    end else begin
      if (ssel && !swr) ref_dout = ref_read(int'(saddr));
      if (ssel && swr && saddr == 4'h5 && sdin[0]) ref_clear();
      else if (hit) ref_master_write(a - BASE, din);
      e.ack = hit;
    end
    e.irq  = ref_full();
    e.dout = ref_dout;
    e.cyc  = cycle_no;
    q.push_back(e);
    #1;
  endtask

  task automatic mw(input logic [7:0] addr, input logic [31:0] d);
    cyc(1, 1, addr, d, 0, 0, 4'h0, 32'h0, 0);
  endtask

  task automatic rd(input logic [3:0] off);
    cyc(0, 0, 8'h00, 32'h0, 1, 0, off, 32'h0, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 8'h00, 32'h0, 0, 0, 4'h0, 32'h0, 0);
  endtask

  task automatic check(input string name, input int cyc_id, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc_id, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("M_ack", e.cyc, {31'b0, M_ack}, {31'b0, e.ack});
        check("s_interrupt", e.cyc, {31'b0, s_interrupt}, {31'b0, e.irq});
        check("S_dout", e.cyc, S_dout, e.dout);
      end
    end
  end

  initial begin
    ref_clear();
    ref_dout = '0;
    cyc(0, 0, 8'h00, 32'h0, 0, 0, 4'h0, 32'h0, 1);
    cyc(0, 0, 8'h00, 32'h0, 1, 0, 4'h4, 32'h0, 1);
    idle();

    // Full in-order burst, status and word readback.
    mw(8'h60, 32'h11111111);
    mw(8'h61, 32'h22222222);
    mw(8'h62, 32'h33333333);
    mw(8'h63, 32'h44444444);
    idle();
    for (int i = 0; i < 5; i++) rd(4'(i));
    idle();

    // Overrun while full, host write to read-only offsets ignored.
    mw(8'h61, 32'h55555555);
    rd(4'h1); rd(4'h4);
    cyc(0, 0, 8'h00, 32'h0, 1, 1, 4'h1, 32'hFFFFFFFF, 0);
    cyc(0, 0, 8'h00, 32'h0, 1, 1, 4'h4, 32'hFFFFFFFF, 0);
    rd(4'h1); rd(4'h6);

    // Clear colliding with a master write: clear wins, ack still given.
    cyc(1, 1, 8'h60, 32'hDEADBEEF, 1, 1, 4'h5, 32'h1, 0);
    idle();
    rd(4'h0); rd(4'h4);

    // Out-of-order writes.
    mw(8'h62, 32'hAAAA0002);
    mw(8'h60, 32'hAAAA0000);
    rd(4'h4); rd(4'h2); rd(4'h0);
    cyc(0, 0, 8'h00, 32'h0, 1, 1, 4'h5, 32'h1, 0);

    // Duplicate index, then reset mid-burst and a fresh burst.
    mw(8'h60, 32'h01010101);
    mw(8'h60, 32'h02020202);
    rd(4'h4); rd(4'h0);
    cyc(0, 0, 8'h00, 32'h0, 0, 0, 4'h0, 32'h0, 1);
    rd(4'h4);
    for (int i = 0; i < 4; i++) mw(8'(BASE + i), 32'hC0DE0000 + i);
    rd(4'h4); rd(4'h3);
    cyc(0, 0, 8'h00, 32'h0, 1, 1, 4'h5, 32'h1, 0);

    // Out-of-window addresses and non-write requests.
    mw(8'h64, 32'h12345678);
    mw(8'h5F, 32'h12345678);
    cyc(1, 0, 8'h60, 32'h12345678, 0, 0, 4'h0, 32'h0, 0);
    rd(4'h4);

    // Back-to-back bursts mixed with random host traffic.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] sa;
      sa = 4'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
          8'(8'h5E + $urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
          sa, $urandom, 1'($urandom_range(0, 63) == 0));
    end

    idle(); idle();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
